// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencing logic.
// Holds the controller state encoding and the fixed pipeline latencies it schedules around.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUTEN = 3'd3,
        ST_HOLD  = 3'd4
    } mac_ctrl_state_t;

    // Register stages inside the MAC between operand input and the accumulator.
    localparam int MAC_PIPE_LAT = 3;

    localparam int MAC_MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/mac_valid_pipe.sv
// Shift-register delay line for issue tokens; dout marks the cycle a product reaches the accumulator.
// pending reports tokens that will still emerge in a later cycle (all stages but the output one).
module mac_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic din,
    output logic dout,
    output logic pending
);

    logic stage_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (clear) begin
                        stage_reg[gi] <= 1'b0;
                    end else begin
                        stage_reg[gi] <= din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (clear) begin
                        stage_reg[gi] <= 1'b0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage_reg[i];
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/mac_ctrl.sv
// Sequencer for a pipelined MAC unit: issues operand reads, tracks them to the accumulator,
// then pulses the output enable and holds the result until the consumer takes it.
module mac_ctrl
    import mac_pkg::*;
#(
    parameter int AWIDTH  = 10,
    parameter int LWIDTH  = 10,
    parameter int MEM_LAT = MAC_MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LWIDTH-1:0] len,
    input  logic [AWIDTH-1:0] x_base,
    input  logic [AWIDTH-1:0] w_base,
    output logic              rd_en,
    output logic [AWIDTH-1:0] x_addr,
    output logic [AWIDTH-1:0] w_addr,
    output logic              mac_reset,
    output logic              mac_accum_we,
    output logic              mac_out_en,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PIPE_DEPTH = MEM_LAT + MAC_PIPE_LAT;

    mac_ctrl_state_t   state_reg;
    logic [LWIDTH-1:0] cnt_reg;
    logic [AWIDTH-1:0] x_addr_reg;
    logic [AWIDTH-1:0] w_addr_reg;
    logic              rd_en_reg;
    logic              mac_reset_reg;
    logic              out_en_reg;
    logic              out_valid_reg;
    logic              accum_we_pipe;
    logic              pipe_pending;

    mac_valid_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_valid_pipe (
        .clk    (clk),
        .clear  (reset),
        .din    (rd_en_reg),
        .dout   (accum_we_pipe),
        .pending(pipe_pending)
    );

    // cnt_reg holds the issues still to go after the current one, so it never exceeds len-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            x_addr_reg    <= '0;
            w_addr_reg    <= '0;
            rd_en_reg     <= 1'b0;
            mac_reset_reg <= 1'b0;
            out_en_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            rd_en_reg     <= 1'b0;
            mac_reset_reg <= 1'b0;
            out_en_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mac_reset_reg <= 1'b1;
                        if (len != '0) begin
                            state_reg  <= ST_ISSUE;
                            rd_en_reg  <= 1'b1;
                            x_addr_reg <= x_base;
                            w_addr_reg <= w_base;
                            cnt_reg    <= len - LWIDTH'(1);
                        end else begin
                            state_reg <= ST_OUTEN;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cnt_reg != '0) begin
                        rd_en_reg  <= 1'b1;
                        x_addr_reg <= x_addr_reg + AWIDTH'(1);
                        w_addr_reg <= w_addr_reg + AWIDTH'(1);
                        cnt_reg    <= cnt_reg - LWIDTH'(1);
                    end else begin
                        state_reg  <= ST_DRAIN;
                        x_addr_reg <= '0;
                        w_addr_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The last token may be at the pipe output now; that write lands this cycle.
                    if (!pipe_pending) begin
                        state_reg  <= ST_OUTEN;
                        out_en_reg <= 1'b1;
                    end
                end
                ST_OUTEN: begin
                    // Entered straight from IDLE (len=0) the clear is still in flight, so the
                    // enable pulse waits one cycle to land after it.
                    if (out_en_reg) begin
                        state_reg     <= ST_HOLD;
                        out_valid_reg <= 1'b1;
                    end else begin
                        out_en_reg <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low combinationally so they are already quiet in the reset cycle itself.
    assign rd_en        = rd_en_reg & ~reset;
    assign x_addr       = x_addr_reg & {AWIDTH{~reset}};
    assign w_addr       = w_addr_reg & {AWIDTH{~reset}};
    assign mac_reset    = mac_reset_reg & ~reset;
    assign mac_accum_we = accum_we_pipe & ~reset;
    assign mac_out_en   = out_en_reg & ~reset;
    assign busy         = (state_reg != ST_IDLE) & ~reset;
    assign out_valid    = out_valid_reg & ~reset;

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameter AWIDTH, default 10: operand memory address width.
REQ-002 Parameter LWIDTH, default 10: vector length width.
REQ-003 Parameter MEM_LAT, default 1: operand memory read latency in cycles.
REQ-004 Port clk  in  1: clock. All logic SHALL be rising-edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port start  in  1: start request. Sampled only in IDLE.
REQ-007 Port len  in  LWIDTH: number of products to accumulate. Latched on start.
REQ-008 Ports x_base, w_base  in  AWIDTH each: first operand addresses. Latched on start.
REQ-009 Ports rd_en  out  1, x_addr  out  AWIDTH, w_addr  out  AWIDTH: operand memory read request.
REQ-010 Ports mac_reset, mac_accum_we, mac_out_en  out  1 each: MAC unit controls.
REQ-011 Port busy  out  1: high in every state except IDLE.
REQ-012 Port out_valid  out  1, out_ready  in  1: result handshake. The MAC y output is the data.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, DRAIN, OUTEN and HOLD.
REQ-014 IDLE with start=1 at cycle 0 SHALL latch len and the bases. Next state: ISSUE if len>0, otherwise OUTEN.
REQ-015 ISSUE SHALL assert rd_en for exactly len consecutive cycles, starting at cycle 1.
REQ-016 In ISSUE, x_addr and w_addr SHALL equal base+k for issue index k=0..len-1, and SHALL wrap modulo 2^AWIDTH.
REQ-017 mac_reset SHALL be high only in the first cycle after start acceptance (cycle 1). This holds for len=0 too.
REQ-018 Every issue SHALL push a token into a delay line of depth MEM_LAT+3. mac_accum_we SHALL be the delay line output. With MEM_LAT=1, the issue at cycle t gives mac_accum_we at cycle t+4.
REQ-019 mac_reset and mac_accum_we SHALL never be high in the same cycle.
REQ-020 After the last issue, the FSM SHALL enter DRAIN. It SHALL stay in DRAIN until the delay line is empty.
REQ-021 After DRAIN, the FSM SHALL enter OUTEN and assert mac_out_en for exactly one cycle.
REQ-022 After OUTEN, the FSM SHALL enter HOLD. In HOLD, out_valid SHALL be 1 and the MAC y output is stable.
REQ-023 In HOLD, out_valid && out_ready SHALL return the FSM to IDLE in the next cycle.
REQ-024 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-025 start in the same cycle as the HOLD handshake SHALL be ignored. A new start is accepted in IDLE only.
REQ-026 len=0 SHALL produce mac_reset at cycle 1, mac_out_en at cycle 2 and out_valid from cycle 3, with result y=0.
REQ-027 Maximum len = 2^LWIDTH-1. The issue counter SHALL NOT overflow.
REQ-028 Timing for len=n≥1, start at cycle 0:
- rd_en: cycles 1..n
- mac_accum_we: cycles 5..n+4
- mac_out_en: cycle n+5
- out_valid: from cycle n+6

Reset
REQ-029 reset=1 SHALL force, at the next clock edge: state to IDLE, delay line cleared, counters and latched registers cleared.
REQ-030 While reset=1, and in the cycle after it, every output SHALL be 0. This includes rd_en, both addresses, mac_reset, mac_accum_we, mac_out_en, busy and out_valid.
REQ-031 reset=1 mid-ISSUE or mid-DRAIN SHALL abort the operation. No further mac_accum_we or mac_out_en pulses SHALL occur for it.
REQ-032 reset SHALL have priority over start and over out_ready.

Structure
REQ-033 The shared package mac_pkg SHALL hold:
- the state enum mac_ctrl_state_t
- constant MAC_PIPE_LAT=3, the MAC register stages between operand input and accumulate
- the default MEM_LAT
REQ-034 The delay line SHALL be the sub-module mac_valid_pipe, parameterised by DEPTH. It SHALL have 1-bit in/out and a synchronous clear.
REQ-035 The implementation SHALL NOT contain any arithmetic datapath. The MAC arithmetic stays in the MAC unit.

Verification
REQ-036 len=4, x=1.0, w=2.0 (Q8.8: 256, 512), out_ready=1 -> accum_we cycles 5-8, out_en cycle 9, out_valid cycle 10, y=2048.
REQ-037 len=0 -> mac_reset cycle 1, out_en cycle 2, out_valid cycle 3, y=0, no rd_en and no accum_we.
REQ-038 x_base=2^AWIDTH-2, len=4 -> x_addr sequence 1022,1023,0,1 (AWIDTH=10).
REQ-039 out_ready held 0 for 10 cycles in HOLD -> out_valid stays 1 and y stays stable. A start pulse during that time is ignored. Raising out_ready -> IDLE the next cycle.
REQ-040 reset pulsed at cycle 3 of a len=8 run -> all outputs 0, no later accum_we or out_en. A new len=2 run then gives the correct y.
REQ-041 Back-to-back len=3 runs with random operands -> each y matches a reference-model dot product with the MAC rounding rule. mac_reset never overlaps mac_accum_we.
